// File: rtl/sda_kernel_ctrl_irq_regs.sv
// Kernel control register bank: per-channel go/done handshake sequencing,
// auto-restart, and a level interrupt built from GIE, IER and ISR.
//
// state       | meaning
// ST_IDLE     | no run in progress, waiting for a start write
// ST_GO_REQ   | go_r high, waiting for go_a
// ST_GO_REL   | go_r low, waiting for go_a to drop
// ST_BUSY     | action running, waiting for done_r
// ST_DONE_ACK | done_a high, waiting for done_r to drop
module sda_kernel_ctrl_irq_regs #(
  parameter int NUM_CH     = 1,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  reg_req,
  output logic                  reg_ack,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic [31:0]           reg_rdata,
  output logic [NUM_CH-1:0]     go_r,
  input  logic [NUM_CH-1:0]     go_a,
  input  logic [NUM_CH-1:0]     done_r,
  output logic [NUM_CH-1:0]     done_a,
  output logic                  interrupt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO_REQ,
    ST_GO_REL,
    ST_BUSY,
    ST_DONE_ACK
  } ch_state_t;

  logic              wr_req;
  logic              rd_req;
  logic [31:0]       addr_ext;
  logic              gie_q;
  logic [NUM_CH-1:0] ier_q;
  logic [NUM_CH-1:0] isr_q;
  logic [NUM_CH-1:0] isr_set;
  logic [NUM_CH-1:0] w1c_mask;
  logic [NUM_CH-1:0] ctrl_sel;
  logic [NUM_CH-1:0] done_bits;
  logic [NUM_CH-1:0] auto_bits;
  logic [NUM_CH-1:0] idle_bits;
  logic [NUM_CH-1:0] start_bits;
  logic [31:0]       rdata_d;
  logic              unused_wdata;

  assign wr_req       = reg_req & reg_write_en;
  assign rd_req       = reg_req & ~reg_write_en;
  assign addr_ext     = 32'(reg_addr);
  assign unused_wdata = ^reg_wdata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_t state_q;
    ch_state_t state_d;
    logic      ctrl_wr;
    logic      done_evt;
    logic      done_q;
    logic      auto_q;

    assign ctrl_sel[c] = (addr_ext == 32'(4 + c));
    assign ctrl_wr     = wr_req & ctrl_sel[c];
    assign done_evt    = (state_q == ST_BUSY) & done_r[c];

    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_IDLE:     if (ctrl_wr && reg_wdata[0]) state_d = ST_GO_REQ;
        ST_GO_REQ:   if (go_a[c])                 state_d = ST_GO_REL;
        ST_GO_REL:   if (!go_a[c])                state_d = ST_BUSY;
        ST_BUSY:     if (done_r[c])               state_d = ST_DONE_ACK;
        ST_DONE_ACK: if (!done_r[c])              state_d = auto_q ? ST_GO_REQ : ST_IDLE;
        default:                                  state_d = ST_IDLE;
      endcase
    end

    // A done event on the same edge as a read-clear keeps the bit set.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        state_q <= ST_IDLE;
        done_q  <= 1'b0;
        auto_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        done_q  <= done_evt | (done_q & ~(rd_req & ctrl_sel[c]));
        if (ctrl_wr) auto_q <= reg_wdata[7];
      end
    end

    assign go_r[c]       = (state_q == ST_GO_REQ);
    assign done_a[c]     = (state_q == ST_DONE_ACK);
    assign idle_bits[c]  = (state_q == ST_IDLE);
    assign start_bits[c] = (state_q == ST_GO_REQ);
    assign done_bits[c]  = done_q;
    assign auto_bits[c]  = auto_q;
    assign isr_set[c]    = done_evt & ier_q[c];
  end

  always_comb begin
    w1c_mask = '0;
    if (wr_req && addr_ext == 32'd2) w1c_mask = reg_wdata[NUM_CH-1:0];
  end

  always_comb begin
    rdata_d = '0;
    if (addr_ext == 32'd0) rdata_d[0] = gie_q;
    if (addr_ext == 32'd1) rdata_d[NUM_CH-1:0] = ier_q;
    if (addr_ext == 32'd2) rdata_d[NUM_CH-1:0] = isr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ctrl_sel[c]) begin
        rdata_d[0] = start_bits[c];
        rdata_d[1] = done_bits[c];
        rdata_d[2] = idle_bits[c];
        rdata_d[7] = auto_bits[c];
      end
    end
  end

  // ISR set outranks a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      gie_q     <= 1'b0;
      ier_q     <= '0;
      isr_q     <= '0;
      interrupt <= 1'b0;
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      if (wr_req && addr_ext == 32'd0) gie_q <= reg_wdata[0];
      if (wr_req && addr_ext == 32'd1) ier_q <= reg_wdata[NUM_CH-1:0];
      isr_q     <= (isr_q & ~w1c_mask) | isr_set;
      interrupt <= gie_q & (|isr_q);
      reg_ack   <= reg_req;
      reg_rdata <= rd_req ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_sda_kernel_ctrl_irq_regs.sv
// Bench for sda_kernel_ctrl_irq_regs (two channels): directed handshake and
// interrupt scenarios, then randomized register traffic against a register model.
module tb_sda_kernel_ctrl_irq_regs;
  localparam int NCH = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        reg_req = 1'b0;
  logic        reg_ack;
  logic        reg_write_en = 1'b0;
  logic [3:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic [1:0]  go_r;
  logic [1:0]  go_a = '0;
  logic [1:0]  done_r = '0;
  logic [1:0]  done_a;
  logic        interrupt;

  sda_kernel_ctrl_irq_regs #(.NUM_CH(NCH), .ADDR_WIDTH(4)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .reg_req(reg_req), .reg_ack(reg_ack), .reg_write_en(reg_write_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .go_r(go_r), .go_a(go_a), .done_r(done_r), .done_a(done_a),
    .interrupt(interrupt)
  );

  always #5 ap_clk = ~ap_clk;

  int vectors = 0;
  int miscompares = 0;

  // register model; p_* hold updates that land on the next rising edge
  logic       gie_exp;
  logic [1:0] ier_exp, isr_exp, done_exp, auto_exp;
  logic       p_gie_we, p_gie, p_ier_we;
  logic [1:0] p_ier, p_w1c, p_set, p_dset, p_dclr, p_auto_we, p_auto;

  bit rsp_en [NCH];
  int ph [NCH];
  int tmr [NCH];
  int wdog [NCH];
  int go_cnt [NCH];
  int done_cnt [NCH];

  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_pending();
    p_gie_we = 0; p_gie = 0; p_ier_we = 0; p_ier = 0; p_w1c = 0;
    p_set = 0; p_dset = 0; p_dclr = 0; p_auto_we = 0; p_auto = 0;
  endtask

  task automatic model_reset();
    gie_exp = 0; ier_exp = 0; isr_exp = 0; done_exp = 0; auto_exp = 0;
    clear_pending();
    for (int c = 0; c < NCH; c++) begin
      ph[c] = 0; tmr[c] = 0; wdog[c] = 0;
    end
  endtask

  task automatic commit();
    isr_exp  = (isr_exp & ~p_w1c) | p_set;
    done_exp = (done_exp & ~p_dclr) | p_dset;
    if (p_gie_we) gie_exp = p_gie;
    if (p_ier_we) ier_exp = p_ier;
    auto_exp = (auto_exp & ~p_auto_we) | (p_auto & p_auto_we);
    clear_pending();
  endtask

  // only called while the channel is known to be BUSY
  task automatic raise_done(input int c);
    done_r[c] = 1'b1;
    p_dset[c] = 1'b1;
    p_set[c]  = p_set[c] | ier_exp[c];
  endtask

  task automatic rsp_step();
    for (int c = 0; c < NCH; c++) begin
      if (!rsp_en[c]) continue;
      case (ph[c])
        0: if (go_r[c]) begin tmr[c] = int'($urandom_range(0, 3)); ph[c] = 1; end
        1: if (tmr[c] == 0) begin go_a[c] = 1'b1; wdog[c] = 0; ph[c] = 2; end
           else tmr[c]--;
        2: if (!go_r[c]) begin tmr[c] = int'($urandom_range(0, 3)); ph[c] = 3; end
           else begin
             wdog[c]++;
             if (wdog[c] > 40) begin
               chk("rsp_go_release", 32'(go_r[c]), 32'd0);
               go_a[c] = 1'b0; ph[c] = 0;
             end
           end
        3: if (tmr[c] == 0) begin
             go_a[c] = 1'b0; go_cnt[c]++;
             tmr[c] = int'($urandom_range(4, 10)); ph[c] = 4;
           end else tmr[c]--;
        4: if (tmr[c] == 0) begin raise_done(c); wdog[c] = 0; ph[c] = 5; end
           else tmr[c]--;
        5: if (done_a[c]) begin tmr[c] = int'($urandom_range(0, 3)); ph[c] = 6; end
           else begin
             wdog[c]++;
             if (wdog[c] > 40) begin
               chk("rsp_done_ack", 32'(done_a[c]), 32'd1);
               done_r[c] = 1'b0; ph[c] = 0;
             end
           end
        6: if (tmr[c] == 0) begin done_r[c] = 1'b0; done_cnt[c]++; ph[c] = 0; end
           else tmr[c]--;
        default: ph[c] = 0;
      endcase
    end
  endtask

  // one cycle: apply pending model updates across the edge, check interrupt
  task automatic tick();
    logic int_pred;
    int_pred = gie_exp & (|isr_exp);
    commit();
    @(negedge ap_clk);
    chk("interrupt", 32'(interrupt), 32'(int_pred));
    rsp_step();
  endtask

  // issued at a falling edge; returns at the falling edge where reg_ack is high
  task automatic reg_access(input bit wr, input int addr, input logic [31:0] wd,
                            output logic [31:0] rdv);
    logic [31:0] exp_rd;
    logic [31:0] mask;
    exp_rd = '0;
    mask   = 32'hFFFF_FFFF;
    reg_req = 1'b1; reg_write_en = wr; reg_addr = 4'(addr); reg_wdata = wd;
    if (wr) begin
      case (addr)
        0: begin p_gie_we = 1; p_gie = wd[0]; end
        1: begin p_ier_we = 1; p_ier = wd[1:0]; end
        2: p_w1c = wd[1:0];
        4, 5: begin p_auto_we[addr-4] = 1'b1; p_auto[addr-4] = wd[7]; end
        default: ;
      endcase
    end else begin
      case (addr)
        0: exp_rd = {31'b0, gie_exp};
        1: exp_rd = {30'b0, ier_exp};
        2: exp_rd = {30'b0, isr_exp};
        4, 5: begin
          exp_rd = {24'b0, auto_exp[addr-4], 5'b0, done_exp[addr-4], 1'b0};
          mask   = 32'hFFFF_FFFA;
          p_dclr[addr-4] = 1'b1;
        end
        default: exp_rd = '0;
      endcase
    end
    tick();
    reg_req = 1'b0; reg_write_en = 1'b0;
    chk("ack", 32'(reg_ack), 32'd1);
    rdv = reg_rdata;
    if (wr) chk("wr_rdata", reg_rdata, 32'd0);
    else    chk($sformatf("rd_a%0d", addr), reg_rdata & mask, exp_rd & mask);
  endtask

  task automatic go_handshake(input int c);
    chk($sformatf("go_r%0d_hi", c), 32'(go_r[c]), 32'd1);
    go_a[c] = 1'b1;
    tick();
    chk($sformatf("go_r%0d_rel", c), 32'(go_r[c]), 32'd0);
    go_a[c] = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_done(input int c, input int target);
    int n;
    n = 0;
    while (done_cnt[c] < target && n < 1000) begin tick(); n++; end
    chk($sformatf("runs_ch%0d", c), 32'(done_cnt[c]), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    int n;
    model_reset();
    for (int c = 0; c < NCH; c++) begin
      rsp_en[c] = 0; go_cnt[c] = 0; done_cnt[c] = 0;
    end
    repeat (3) @(negedge ap_clk);
    chk("rst_ack", 32'(reg_ack), 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_go_r", 32'(go_r), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_irq", 32'(interrupt), 32'd0);
    ap_rst_n = 1'b1;
    tick();

    // reset register contents
    reg_access(0, 4, 0, rd); chk("idle_ch0", rd, 32'h4);
    reg_access(0, 5, 0, rd); chk("idle_ch1", rd, 32'h4);
    foreach (rd[i]) if (i < 1) ; // keep rd referenced simply
    reg_access(0, 0, 0, rd); chk("gie_rst", rd, 32'h0);
    reg_access(0, 1, 0, rd); chk("ier_rst", rd, 32'h0);
    reg_access(0, 2, 0, rd); chk("isr_rst", rd, 32'h0);
    reg_access(0, 3, 0, rd);
    reg_access(1, 9, 32'hFFFF_FFFF, rd);
    reg_access(0, 9, 0, rd); chk("unmapped", rd, 32'h0);

    // manual run on channel 0
    reg_access(1, 4, 32'h1, rd);
    chk("start_lat", 32'(go_r[0]), 32'd1);
    reg_access(0, 4, 0, rd); chk("ctrl_goreq", rd, 32'h1);
    go_handshake(0);
    reg_access(0, 4, 0, rd); chk("ctrl_busy", rd, 32'h0);
    raise_done(0);
    tick();
    chk("done_a_hi", 32'(done_a[0]), 32'd1);
    reg_access(0, 4, 0, rd); chk("ctrl_done", rd, 32'h2);
    reg_access(0, 4, 0, rd); chk("ctrl_rdclr", rd, 32'h0);
    done_r[0] = 1'b0;
    tick();
    chk("done_a_lo", 32'(done_a[0]), 32'd0);
    reg_access(0, 4, 0, rd); chk("ctrl_idle", rd, 32'h4);

    // interrupt path: only channel 1 enabled
    reg_access(1, 0, 32'h1, rd);
    reg_access(1, 1, 32'h2, rd);
    rsp_en[0] = 1;
    reg_access(1, 4, 32'h1, rd);
    wait_done(0, 1);
    rsp_en[0] = 0;
    tick();
    reg_access(0, 2, 0, rd); chk("isr_ch0_masked", rd, 32'h0);
    reg_access(1, 5, 32'h1, rd);
    go_handshake(1);
    raise_done(1);
    tick();
    chk("irq_m1", 32'(interrupt), 32'd0);
    tick();
    chk("irq_m2", 32'(interrupt), 32'd1);
    reg_access(0, 2, 0, rd); chk("isr_ch1", rd, 32'h2);
    done_r[1] = 1'b0;
    tick();
    reg_access(1, 2, 32'h2, rd);
    chk("irq_k1", 32'(interrupt), 32'd1);
    tick();
    chk("irq_k2", 32'(interrupt), 32'd0);

    // auto-restart on channel 1
    rsp_en[1] = 1; go_cnt[1] = 0; done_cnt[1] = 0;
    reg_access(1, 5, 32'h81, rd);
    n = 0;
    while (done_cnt[1] < 3 && n < 1000) begin tick(); n++; end
    reg_access(1, 5, 32'h0, rd);
    wait_done(1, 4);
    repeat (20) tick();
    chk("auto_go_cnt", 32'(go_cnt[1]), 32'd4);
    reg_access(0, 5, 0, rd); chk("auto_end_done", rd, 32'h6);
    reg_access(0, 5, 0, rd); chk("auto_end_idle", rd, 32'h4);
    rsp_en[1] = 0;

    // coincident events on channel 0
    reg_access(1, 1, 32'h3, rd);
    reg_access(1, 4, 32'h1, rd);
    go_handshake(0);
    raise_done(0);
    reg_access(1, 2, 32'h1, rd);
    reg_access(0, 2, 0, rd); chk("isr_set_wins", rd & 32'h1, 32'h1);
    done_r[0] = 1'b0;
    tick();
    reg_access(1, 4, 32'h1, rd);
    go_handshake(0);
    reg_access(1, 4, 32'h1, rd);
    chk("busy_start_ign", 32'(go_r[0]), 32'd0);
    reg_access(0, 4, 0, rd); chk("busy_done_old", rd, 32'h2);
    chk("busy_no_go", 32'(go_r[0]), 32'd0);
    raise_done(0);
    reg_access(0, 4, 0, rd); chk("rdclr_pre", rd, 32'h0);
    reg_access(0, 4, 0, rd); chk("rdclr_kept", rd, 32'h2);
    done_r[0] = 1'b0;
    tick();
    reg_access(0, 4, 0, rd); chk("busy_start_idle", rd, 32'h4);

    // randomized register traffic with free-running action responders
    for (int c = 0; c < NCH; c++) begin rsp_en[c] = 1; ph[c] = 0; end
    for (int i = 0; i < 250; i++) begin
      reg_access(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom, rd);
      repeat ($urandom_range(0, 3)) tick();
    end
    reg_access(1, 4, 32'h0, rd);
    reg_access(1, 5, 32'h0, rd);
    quiet = 0; n = 0;
    while (quiet < 10 && n < 2000) begin
      tick(); n++;
      if (ph[0] == 0 && ph[1] == 0 && go_r == 2'b00 && done_a == 2'b00) quiet++;
      else quiet = 0;
    end
    chk("drain", 32'(quiet), 32'd10);
    for (int c = 0; c < NCH; c++) rsp_en[c] = 0;

    // reset in the middle of a go handshake
    reg_access(1, 0, 32'h1, rd);
    reg_access(1, 1, 32'h3, rd);
    reg_access(1, 5, 32'h80, rd);
    reg_access(1, 4, 32'h1, rd);
    chk("pre_rst_go", 32'(go_r[0]), 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("async_rst_go", 32'(go_r[0]), 32'd0);
    go_a = '0; done_r = '0;
    model_reset();
    @(negedge ap_clk);
    @(negedge ap_clk);
    chk("rst_irq2", 32'(interrupt), 32'd0);
    ap_rst_n = 1'b1;
    tick();
    reg_access(0, 0, 0, rd); chk("gie_rst2", rd, 32'h0);
    reg_access(0, 1, 0, rd); chk("ier_rst2", rd, 32'h0);
    reg_access(0, 2, 0, rd); chk("isr_rst2", rd, 32'h0);
    reg_access(0, 4, 0, rd); chk("ctrl0_rst2", rd, 32'h4);
    reg_access(0, 5, 0, rd); chk("ctrl1_rst2", rd, 32'h4);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
